// File: rtl/division_controller.sv
// rtl/division_controller.sv - sequences start/shift/load/out strobes for a restoring divider
// Optional fast divide-by-zero path enabled by DIV_CTRL_ZERO_CHECK_EN.
module division_controller #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_dividend,
   input  logic [WIDTH-1:0] req_divisor,
   output logic             start,
   output logic             shift,
   output logic             load,
   output logic             out,
   output logic [WIDTH-1:0] dividend,
   output logic [WIDTH-1:0] divisor,
   input  logic [WIDTH-1:0] dp_quotient,
   input  logic [WIDTH-1:0] dp_remainder,
   output logic             res_valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_SHIFT,
      S_LOAD1,
      S_LOAD2,
      S_OUT,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_CTRL_ZERO_CHECK_EN
   logic             div_zero_q, div_zero_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef DIV_CTRL_ZERO_CHECK_EN
         div_zero_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
`ifdef DIV_CTRL_ZERO_CHECK_EN
         div_zero_q  <= div_zero_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
`ifdef DIV_CTRL_ZERO_CHECK_EN
      div_zero_d  = div_zero_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               dividend_d = req_dividend;
               divisor_d  = req_divisor;
               cnt_d      = '0;
               state_d    = S_START;
`ifdef DIV_CTRL_ZERO_CHECK_EN
               // Zero divisor skips the datapath entirely and reports at once.
               if (req_divisor == '0) begin
                  state_d     = S_DONE;
                  quotient_d  = '1;
                  remainder_d = req_dividend;
                  div_zero_d  = 1'b1;
               end
`endif
            end
         end
         S_START:   state_d = S_SHIFT;
         S_SHIFT:   state_d = S_LOAD1;
         S_LOAD1:   state_d = S_LOAD2;
         S_LOAD2: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LAST_ITER) ? S_OUT : S_SHIFT;
         end
         S_OUT:     state_d = S_CAPTURE;
         S_CAPTURE: begin
            quotient_d  = dp_quotient;
            remainder_d = dp_remainder;
`ifdef DIV_CTRL_ZERO_CHECK_EN
            div_zero_d  = 1'b0;
`endif
            state_d     = S_DONE;
         end
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Ready is masked by reset because the state register already reads IDLE then.
   assign req_ready = rst_n && (state_q == S_IDLE);
   assign start     = (state_q == S_START);
   assign shift     = (state_q == S_SHIFT);
   assign load      = (state_q == S_LOAD1) || (state_q == S_LOAD2);
   assign out       = (state_q == S_OUT);
   assign res_valid = (state_q == S_DONE);
   assign dividend  = dividend_q;
   assign divisor   = divisor_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
`ifdef DIV_CTRL_ZERO_CHECK_EN
   assign div_zero  = div_zero_q;
`else
   assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_division_controller.sv
// tb/tb_division_controller.sv - checks division_controller against a cycle-phase reference model
module tb_division_controller;
   localparam int W = 8;
   localparam logic [W-1:0] ONES = '1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] req_dividend = '0;
   logic [W-1:0] req_divisor = '0;
   logic         start, shift, load, out;
   logic [W-1:0] dividend, divisor;
   logic [W-1:0] dp_quotient = '0;
   logic [W-1:0] dp_remainder = '0;
   logic         res_valid;
   logic [W-1:0] quotient, remainder;
   logic         div_zero;

   division_controller #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .start(start), .shift(shift), .load(load), .out(out),
      .dividend(dividend), .divisor(divisor),
      .dp_quotient(dp_quotient), .dp_remainder(dp_remainder),
      .res_valid(res_valid), .quotient(quotient), .remainder(remainder),
      .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] divide(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) return {ONES, a};
      return {a / b, a % b};
   endfunction

   // Reference: ph counts cycles since acceptance (1 = first cycle after the accepting edge).
   logic         m_busy;
   int           ph;
   logic [W-1:0] m_a, m_b, m_q, m_r;
   logic         m_dz;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; ph <= 0;
         m_a <= '0; m_b <= '0; m_q <= '0; m_r <= '0; m_dz <= 1'b0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_a <= req_dividend; m_b <= req_divisor; m_busy <= 1'b1; ph <= 1;
`ifdef DIV_CTRL_ZERO_CHECK_EN
            if (req_divisor == '0) begin
               ph <= 3 * W + 4; m_q <= ONES; m_r <= req_dividend; m_dz <= 1'b1;
            end
`endif
         end
      end else begin
         if (ph == 3 * W + 3) begin
            {m_q, m_r} <= divide(m_a, m_b);
            m_dz <= 1'b0;
         end
         if (ph == 3 * W + 4) begin
            m_busy <= 1'b0; ph <= 0;
         end else begin
            ph <= ph + 1;
         end
      end
   end

   always @(negedge clk) begin
      logic in_body;
      in_body = m_busy && ph >= 2 && ph <= 3 * W + 1;
      chk("start", start, m_busy && ph == 1);
      chk("shift", shift, in_body && (ph - 2) % 3 == 0);
      chk("load", load, in_body && (ph - 2) % 3 != 0);
      chk("out", out, m_busy && ph == 3 * W + 2);
      chk("res_valid", res_valid, m_busy && ph == 3 * W + 4);
      chk("req_ready", req_ready, rst_n && !m_busy);
      chk("dividend", dividend, m_a);
      chk("divisor", divisor, m_b);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_zero", div_zero, m_dz);
   end

   // The datapath result is only presented during the capture cycle; noise otherwise.
   task automatic step();
      @(posedge clk);
      #2;
      if (m_busy && ph == 3 * W + 3) {dp_quotient, dp_remainder} = divide(m_a, m_b);
      else begin
         dp_quotient  = W'($urandom);
         dp_remainder = W'($urandom);
      end
   endtask

   int lat, n_s, n_h, n_l, n_o, out_cyc, rdy_hi, tries;

   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
      logic acc;
      acc = 1'b0;
      req_valid = 1'b1; req_dividend = a; req_divisor = b;
      tries = 0;
      for (int i = 0; i < 60; i++) begin
         acc = req_ready;
         tries++;
         step();
         if (acc) break;
      end
      chk("accept", acc, 1);
   endtask

   task automatic wait_result();
      n_s = 0; n_h = 0; n_l = 0; n_o = 0; lat = 0; out_cyc = 0; rdy_hi = 0;
      for (int c = 1; c <= 40; c++) begin
         n_s += int'(start); n_h += int'(shift); n_l += int'(load); n_o += int'(out);
         if (out) out_cyc = c;
         if (req_ready) rdy_hi++;
         if (res_valid) begin
            lat = c;
            break;
         end
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      chk("rst_ready", req_ready, 0);
      chk("rst_quotient", quotient, 0);
      rst_n = 1'b1;

      accept(8'd7, 8'd2);
      req_valid = 1'b0;
      wait_result();
      chk("t1_latency", lat, 28);
      chk("t1_starts", n_s, 1);
      chk("t1_shifts", n_h, 8);
      chk("t1_loads", n_l, 16);
      chk("t1_outs", n_o, 1);
      chk("t1_out_cycle", out_cyc, 26);
      chk("t1_quotient", quotient, 3);
      chk("t1_remainder", remainder, 1);
      step();

      accept(8'd66, 8'd5);
      wait_result();
      chk("t2a_latency", lat, 28);
      chk("t2a_quotient", quotient, 13);
      chk("t2a_remainder", remainder, 1);
      req_dividend = 8'd32; req_divisor = 8'd4;
      step();
      chk("t2_ready_cycle29", req_ready, 1);
      accept(8'd32, 8'd4);
      chk("t2b_first_try", tries, 1);
      req_valid = 1'b0;
      wait_result();
      chk("t2b_quotient", quotient, 8);
      chk("t2b_remainder", remainder, 0);
      step();

      accept(8'd8, 8'd10);
      req_valid = 1'b0;
      wait_result();
      chk("t3_quotient", quotient, 0);
      chk("t3_remainder", remainder, 8);
      chk("t3_ready_low", rdy_hi, 0);
      step();

      accept(8'd2, 8'd2);
      req_valid = 1'b0;
      repeat (11) step();
      rst_n = 1'b0;
      #1;
      chk("t4_strobes", {start, shift, load, out}, 0);
      chk("t4_res_valid", res_valid, 0);
      chk("t4_remainder", remainder, 0);
      chk("t4_dividend", dividend, 0);
      repeat (2) step();
      rst_n = 1'b1;
      accept(8'd2, 8'd2);
      req_valid = 1'b0;
      wait_result();
      chk("t4_quotient", quotient, 1);
      chk("t4_remainder_after", remainder, 0);
      step();

      accept(8'd5, 8'd0);
      req_valid = 1'b0;
      wait_result();
`ifdef DIV_CTRL_ZERO_CHECK_EN
      chk("t5_latency", lat, 1);
      chk("t5_strobes", n_s + n_h + n_l + n_o, 0);
      chk("t5_div_zero", div_zero, 1);
`else
      chk("t5_latency", lat, 28);
      chk("t5_strobes", n_s + n_h + n_l + n_o, 26);
      chk("t5_div_zero", div_zero, 0);
`endif
      chk("t5_quotient", quotient, 8'hFF);
      chk("t5_remainder", remainder, 5);
      step();

      for (int i = 0; i < 2500; i++) begin
         req_valid    = ($urandom_range(2) != 0);
         req_dividend = W'($urandom);
         req_divisor  = ($urandom_range(5) == 0) ? '0 : W'($urandom);
         if (i == 1234) rst_n = 1'b0;
         if (i == 1236) rst_n = 1'b1;
         step();
      end
      req_valid = 1'b0;
      repeat (35) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
